// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state codes and event counter limits for the alarm sequencer
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ALARM    = 2'd1,
      ST_SILENCED = 2'd2
   } alarm_state_t;

   localparam int EVT_W = 8;
   localparam logic [EVT_W-1:0] EVT_MAX = 8'd255;

endpackage

// File: rtl/blink_divider.sv
// rtl/blink_divider.sv - siren phase generator, starts high and toggles every BLINK_HALF cycles
module blink_divider #(
   parameter int BLINK_HALF = 2
) (
   input  logic clk_2,
   input  logic reset_n,
   input  logic restart,
   input  logic enable,
   output logic phase
);

   localparam logic [7:0] HALF_LIM = 8'(BLINK_HALF - 1);

   logic [7:0] cnt_q;

   // restart wins so every fresh alarm begins on a full high half-period
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         phase <= 1'b0;
      end else if (restart) begin
         cnt_q <= '0;
         phase <= 1'b1;
      end else if (enable) begin
         if (cnt_q == HALF_LIM) begin
            cnt_q <= '0;
            phase <= ~phase;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end else begin
         cnt_q <= '0;
         phase <= 1'b0;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - latched alarm FSM with minimum hold before acknowledge and entry counting
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int BLINK_HALF = 2,
   parameter int HOLD_MIN   = 4
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic             alarm_req,
   input  logic             ack,
   output logic             siren,
   output logic             alarm_active,
   output logic             silenced,
   output logic [EVT_W-1:0] event_count,
   output logic [1:0]       state_o
);

   localparam logic [1:0] S_IDLE     = ST_IDLE;
   localparam logic [1:0] S_ALARM    = ST_ALARM;
   localparam logic [1:0] S_SILENCED = ST_SILENCED;
   localparam logic [7:0] HOLD_LIM   = 8'(HOLD_MIN);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [7:0] hold_q;
   logic       entering;
   logic       phase;

   assign entering = (state_q == S_IDLE) && alarm_req;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (alarm_req) state_d = S_ALARM;
         end
         S_ALARM: begin
            if (ack && (hold_q == HOLD_LIM)) state_d = alarm_req ? S_SILENCED : S_IDLE;
         end
         S_SILENCED: begin
            if (!alarm_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         event_count <= '0;
      end else begin
         state_q <= state_d;
         if (entering) begin
            hold_q <= '0;
            if (event_count != EVT_MAX) event_count <= event_count + 8'd1;
         end else if (state_q == S_ALARM) begin
            if (hold_q != HOLD_LIM) hold_q <= hold_q + 8'd1;
         end else begin
            hold_q <= '0;
         end
      end
   end

   blink_divider #(
      .BLINK_HALF(BLINK_HALF)
   ) u_blink (
      .clk_2  (clk_2),
      .reset_n(reset_n),
      .restart(entering),
      .enable (state_q == S_ALARM),
      .phase  (phase)
   );

   // phase may flip on the exit edge, so the state mask keeps siren dark outside ALARM
   assign alarm_active = (state_q == S_ALARM);
   assign silenced     = (state_q == S_SILENCED);
   assign state_o      = state_q;
   assign siren        = alarm_active & phase;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 2, clk_2 cycles per siren half-period (legal range 1..255).
REQ-002 SHALL have parameter HOLD_MIN, default 4, minimum ALARM cycles before ack is honoured (legal range 1..255).
REQ-003 SHALL have port clk_2  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port alarm_req  input  1  level alarm condition from the combinational alarm/siren logic.
REQ-006 SHALL have port ack  input  1  operator acknowledge level, from a switch.
REQ-007 SHALL have port siren  output  1  blinking siren drive, intended for an LED or SEG bit.
REQ-008 SHALL have port alarm_active  output  1  high while in ALARM.
REQ-009 SHALL have port silenced  output  1  high while in SILENCED.
REQ-010 SHALL have port event_count  output  8  saturating count of alarm entries.
REQ-011 SHALL have port state_o  output  2  current state code, for the LCD debug display.

Function
REQ-012 SHALL implement three states with these codes: IDLE=0, ALARM=1, SILENCED=2; code 3 is illegal and SHALL return to IDLE on the next edge.
REQ-013 In IDLE, alarm_req=1 sampled at an edge SHALL move the block to ALARM at that same edge; alarm_active is high immediately after that edge (1-cycle latency).
REQ-014 Each IDLE->ALARM transition SHALL increment event_count by 1, saturating at 255 with no wrap.
REQ-015 ALARM SHALL be latched: alarm_req falling SHALL NOT leave ALARM.
REQ-016 Hold counter:
- cleared to 0 on ALARM entry;
- increments every cycle spent in ALARM;
- saturates at HOLD_MIN.
REQ-017 In ALARM, ack=1 with hold counter < HOLD_MIN SHALL be ignored.
REQ-018 In ALARM, ack=1 with hold counter = HOLD_MIN SHALL transition as follows: alarm_req=1 -> SILENCED; alarm_req=0 -> IDLE.
REQ-019 In SILENCED:
- ack is ignored;
- alarm_req=0 -> IDLE;
- alarm_req=1 -> stay in SILENCED.
A new alarm therefore requires alarm_req to fall and then rise again.
REQ-020 In IDLE, alarm_req=1 and ack=1 in the same cycle SHALL enter ALARM; ack is ignored.
REQ-021 Siren timing:
- siren SHALL be 1 on the first ALARM cycle;
- it SHALL toggle every BLINK_HALF cycles while in ALARM (pattern for BLINK_HALF=2: 1,1,0,0,1,1,...);
- siren SHALL be 0 in IDLE and SILENCED.
REQ-022 The blink counter SHALL restart on every ALARM entry.
REQ-023 All outputs SHALL be registered or decoded directly from registered state; no combinational path from any input to any output.
REQ-024 alarm_active, silenced and state_o SHALL be mutually consistent in every cycle.

Reset
REQ-025 reset_n=0 SHALL, without waiting for a clock edge, force the following values:
- state IDLE;
- siren=0, alarm_active=0, silenced=0;
- event_count=0, state_o=0;
- hold and blink counters=0.
REQ-026 Asserting reset in mid-ALARM or mid-SILENCED SHALL discard all progress.
REQ-027 After reset_n rises, the first edge SHALL evaluate inputs normally.

Structure
REQ-028 A shared package alarm_pkg SHALL hold the following:
- enum typedef alarm_state_t (2-bit);
- constant EVT_W=8;
- constant EVT_MAX=255.
REQ-029 Blink generation SHALL be one sub-module, blink_divider, with these properties:
- inputs clk_2, reset_n, restart, enable;
- output phase;
- parameterised by BLINK_HALF.
REQ-030 The sequencer FSM, hold counter and event counter SHALL reside in alarm_sequencer itself.

Verification (BLINK_HALF=2, HOLD_MIN=4)
REQ-031 Reset, then pulse alarm_req=1 for 1 cycle -> at the next edge alarm_active=1, state_o=1, event_count=1; siren sequence 1,1,0,0,1,1; ALARM holds after req drops.
REQ-032 In ALARM, ack=1 at ALARM cycle 2 -> ignored. Hold ack=1 with alarm_req=0 until hold count reaches 4 -> IDLE, siren=0, alarm_active=0.
REQ-033 alarm_req held 1, valid ack -> SILENCED (silenced=1, siren=0). Drop req -> IDLE. Raise req -> ALARM, event_count=2.
REQ-034 Drive 260 IDLE->ALARM->IDLE cycles -> event_count reads 255 and stays at 255.
REQ-035 reset_n=0 asynchronously between edges in ALARM -> all outputs 0 before the next clk_2 edge.
REQ-036 In IDLE, alarm_req=1 and ack=1 in the same cycle -> ALARM entered, event_count increments, siren=1.
